// File: rtl/fifo_bist_ctrl.sv
// Run controller for the FIFO memory BIST wrapper: sequences pattern reset, one write+read
// sweep with BIST_EN held, and accumulates comparator mismatches into a pass/fail summary.
module fifo_bist_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int PIPE_LAT   = 2,
   parameter int ERR_WIDTH  = 8
) (
   input  logic                  i_wclk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic                  i_passfail,
   output logic                  o_bist_en,
   output logic                  o_bist_rst,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pass,
   output logic [ERR_WIDTH-1:0]  o_err_cnt,
   output logic [ADDR_WIDTH-1:0] o_fail_addr,
   output logic                  o_fail_valid
);

   localparam int DEPTH   = 2**ADDR_WIDTH;
   localparam int RUN_LEN = 2*DEPTH + PIPE_LAT;
   localparam int CNT_W   = $clog2(RUN_LEN + 1);

   localparam logic [CNT_W-1:0] C_WIN_LO = CNT_W'(DEPTH + PIPE_LAT);
   localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(RUN_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_DONE} state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;

   logic                  w_hit;
   logic [ERR_WIDTH-1:0]  w_err_next;
   logic [ADDR_WIDTH-1:0] w_fail_addr;

   // The window runs to the last run cycle, so only its lower bound needs a compare.
   assign w_hit       = (r_state == S_RUN) && (r_cnt >= C_WIN_LO) && !i_passfail;
   assign w_err_next  = (w_hit && !(&o_err_cnt)) ? o_err_cnt + ERR_WIDTH'(1) : o_err_cnt;
   assign w_fail_addr = ADDR_WIDTH'(r_cnt - C_WIN_LO);

   // NOTE: state and outputs are all registers updated with non-blocking assignments so every
   // read in this block sees the pre-edge value, independent of statement order.
   always_ff @(posedge i_wclk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         o_bist_en    <= 1'b0;
         o_bist_rst   <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_pass       <= 1'b0;
         o_err_cnt    <= '0;
         o_fail_addr  <= '0;
         o_fail_valid <= 1'b0;
      end else begin
         o_bist_rst <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state      <= S_PREP;
                  r_cnt        <= '0;
                  o_bist_rst   <= 1'b1;
                  o_busy       <= 1'b1;
                  o_done       <= 1'b0;
                  o_pass       <= 1'b0;
                  o_err_cnt    <= '0;
                  o_fail_addr  <= '0;
                  o_fail_valid <= 1'b0;
               end
            end
            S_PREP: begin
               if (i_abort) begin
                  r_state <= S_IDLE;
                  o_busy  <= 1'b0;
               end else begin
                  r_state   <= S_RUN;
                  r_cnt     <= '0;
                  o_bist_en <= 1'b1;
               end
            end
            S_RUN: begin
               if (i_abort) begin
                  r_state   <= S_IDLE;
                  o_bist_en <= 1'b0;
                  o_busy    <= 1'b0;
                  o_done    <= 1'b0;
                  o_pass    <= 1'b0;
               end else begin
                  o_err_cnt <= w_err_next;
                  if (w_hit && !o_fail_valid) begin
                     o_fail_addr  <= w_fail_addr;
                     o_fail_valid <= 1'b1;
                  end
                  if (r_cnt == C_LAST) begin
                     r_state   <= S_DONE;
                     o_bist_en <= 1'b0;
                     o_busy    <= 1'b0;
                     o_done    <= 1'b1;
                     o_pass    <= (w_err_next == '0);
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
